mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_watchdog.sv | 44 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, grant owner and the
// fetch/data arbitration rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    // Data wins by default; fetch wins a tie when data took the last completed grant.
    function automatic owner_t arb_pick(input logic if_req, input logic d_req, input logic last_d);
        if (d_req && !(if_req && last_d)) begin
            return OWN_D;
        end
        return OWN_IF;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// WAIT-phase timeout counter: armed by start, fires expired in the TIMEOUT-th
// consecutive cycle without ready, then disarms until the next start.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ready,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        expired = armed_q && !ready && (cnt_q == CW'(TIMEOUT - 1));
        if (start) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (ready || expired) begin
                armed_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one backing memory: IDLE->ISSUE->WAIT->RESP.
// Define MEM_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles with err=1.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_addrmode,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_addrmode,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic                  we_q, we_d;
    logic                  am_q, am_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  last_d_q, last_d_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rsp_dat;
    logic                  wd_expired;
    logic                  issue;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (issue),
        .ready  (mem_ready),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        am_d       = am_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_d_d   = last_d_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        rsp_dat    = '0;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d = ISSUE;
                    owner_d = arb_pick(if_req, d_req, last_d_q);
                    if (owner_d == OWN_D) begin
                        we_d    = d_we;
                        am_d    = d_addrmode;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = 1'b0;
                        am_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A write completion or a timeout abort returns zero data.
                if (mem_ready || wd_expired) begin
                    state_d = RESP;
                    err_d   = !mem_ready;
                    rsp_dat = (mem_ready && !we_q) ? mem_rdata : '0;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = rsp_dat;
                    end else begin
                        if_rdata_d = rsp_dat;
                    end
                end
            end
            RESP: begin
                state_d  = IDLE;
                last_d_d = (owner_q == OWN_D);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            am_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_d_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            am_q       <= am_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_d_q   <= last_d_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign issue        = (state_q == ISSUE);
    assign mem_req      = issue;
    assign mem_we       = issue && we_q;
    assign mem_addrmode = issue && am_q;
    assign mem_addr     = issue ? addr_q : '0;
    assign mem_wdata    = issue ? wdata_q : '0;

    assign if_ready = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_ready  = (state_q == RESP) && (owner_q == OWN_D);
    assign if_err   = if_ready && err_q;
    assign d_err    = d_ready && err_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule
